// File: rtl/cart_bank_ctrl.sv
// Cartridge bank-switch controller: captures the bank scheme once after
// reset, decodes bank hotspots, drives the ROM address {BANK, ADDR} and
// hosts an optional 128-byte Superchip RAM with split write/read windows.
module cart_bank_ctrl (
  input  logic        MCLK,
  input  logic        RES,
  input  logic [1:0]  MODE,
  input  logic        SC_EN,
  input  logic        CS,
  input  logic        R_W,
  input  logic [11:0] ADDR,
  input  logic [7:0]  D_IN,
  input  logic [7:0]  ROM_D,
  output logic        ROM_CS,
  output logic [14:0] ROM_ADDR,
  output logic [7:0]  D_OUT,
  output logic [2:0]  BANK,
  output logic        CFG_DONE
);

  typedef enum logic [1:0] {
    MODE_4K = 2'b00,
    MODE_F8 = 2'b01,
    MODE_F6 = 2'b10,
    MODE_F4 = 2'b11
  } bank_mode_e;

  typedef enum logic {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } cfg_state_e;

  cfg_state_e state_q, state_nxt;
  bank_mode_e mode_q, mode_nxt;
  logic       sc_q, sc_nxt;
  logic [2:0] bank_q, bank_nxt;

  logic [7:0] ram [128];

  logic        active;
  logic        hot_hit;
  logic [2:0]  hot_bank;
  logic [11:0] hot_base;
  logic [2:0]  hot_last;
  logic        in_wr_win;
  logic        in_rd_win;
  logic        ram_we;

  // Highest bank of a scheme; the bank selected right after configuration.
  function automatic logic [2:0] last_bank(input bank_mode_e m);
    case (m)
      MODE_F8: return 3'd1;
      MODE_F6: return 3'd3;
      MODE_F4: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  assign active   = (state_q == ST_RUN) && CS;
  assign CFG_DONE = (state_q == ST_RUN);
  assign BANK     = bank_q;
  assign ROM_ADDR = {bank_q, ADDR};

  // Hotspot table for the captured scheme; bank = ADDR - first hotspot.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    hot_base = 12'hFFF;
    hot_last = 3'd0;
    hot_hit  = 1'b0;
    case (mode_q)
      MODE_F8: begin hot_base = 12'hFF8; hot_last = 3'd1; end
      MODE_F6: begin hot_base = 12'hFF6; hot_last = 3'd3; end
      MODE_F4: begin hot_base = 12'hFF4; hot_last = 3'd7; end
      default: ;
    endcase
    // Only the low three bits matter: every table spans at most 8 entries.
    hot_bank = ADDR[2:0] - hot_base[2:0];
    if (active && (mode_q != MODE_4K) &&
        (ADDR >= hot_base) && (ADDR <= hot_base + {9'd0, hot_last}))
      hot_hit = 1'b1;
  end

  // Superchip windows: $000-$07F write port, $080-$0FF read port.
  assign in_wr_win = sc_q && (ADDR[11:7] == 5'b00000);
  assign in_rd_win = sc_q && (ADDR[11:7] == 5'b00001);

  // Data path and chip select; RAM windows take priority over ROM.
  always_comb begin
    ROM_CS = 1'b0;
    D_OUT  = 8'h00;
    ram_we = 1'b0;
    if (active && in_wr_win) begin
      D_OUT  = 8'hFF;
      ram_we = !R_W;
    end else if (active && in_rd_win) begin
      D_OUT = R_W ? ram[ADDR[6:0]] : 8'hFF;
    end else if (active) begin
      ROM_CS = 1'b1;
      D_OUT  = ROM_D;
    end
  end

  // Next-state: capture configuration once, then follow hotspot hits.
  always_comb begin
    // NOTE: combinational blocks use blocking '=', clocked blocks use '<='.
    state_nxt = state_q;
    mode_nxt  = mode_q;
    sc_nxt    = sc_q;
    bank_nxt  = bank_q;
    if (state_q == ST_UNCFG) begin
      state_nxt = ST_RUN;
      mode_nxt  = bank_mode_e'(MODE);
      sc_nxt    = SC_EN;
      bank_nxt  = last_bank(bank_mode_e'(MODE));
    end else if (hot_hit) begin
      bank_nxt = hot_bank;
    end
  end

  // Configuration and bank registers, cleared asynchronously by RES.
  always_ff @(posedge MCLK or posedge RES) begin
    if (RES) begin
      state_q <= ST_UNCFG;
      mode_q  <= MODE_4K;
      sc_q    <= 1'b0;
      bank_q  <= 3'd0;
    end else begin
      state_q <= state_nxt;
      mode_q  <= mode_nxt;
      sc_q    <= sc_nxt;
      bank_q  <= bank_nxt;
    end
  end

  // Superchip RAM write port. RES clears CFG_DONE at once, which gates
  // ram_we, so a write cycle interrupted by reset never lands.
  always_ff @(posedge MCLK) begin
    // NOTE: the RAM has no reset; its contents must survive RES.
    if (ram_we)
      ram[ADDR[6:0]] <= D_IN;
  end

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Self-checking bench for cart_bank_ctrl: vector tables per bank scheme,
// fed through a scoreboard queue, plus hand-written reset/config sequences.
module tb_cart_bank_ctrl;

  logic        MCLK = 1'b0;
  logic        RES  = 1'b1;
  logic [1:0]  MODE = 2'b01;
  logic        SC_EN = 1'b1;
  logic        CS   = 1'b1;
  logic        R_W  = 1'b1;
  logic [11:0] ADDR = 12'hFFC;
  logic [7:0]  D_IN = 8'h00;
  logic [7:0]  ROM_D;
  logic        ROM_CS;
  logic [14:0] ROM_ADDR;
  logic [7:0]  D_OUT;
  logic [2:0]  BANK;
  logic        CFG_DONE;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        cs;
    logic        rw;
    logic [11:0] addr;
    logic [7:0]  din;
    logic        rom_cs;   // expected ROM_CS
    logic [14:0] raddr;    // expected ROM_ADDR
    logic        use_rom;  // expected D_OUT comes from the ROM model
    logic [7:0]  d;        // expected D_OUT when not from ROM
    logic [2:0]  bank;     // expected BANK after the cycle's edge
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  cart_bank_ctrl dut (
    .MCLK     (MCLK),
    .RES      (RES),
    .MODE     (MODE),
    .SC_EN    (SC_EN),
    .CS       (CS),
    .R_W      (R_W),
    .ADDR     (ADDR),
    .D_IN     (D_IN),
    .ROM_D    (ROM_D),
    .ROM_CS   (ROM_CS),
    .ROM_ADDR (ROM_ADDR),
    .D_OUT    (D_OUT),
    .BANK     (BANK),
    .CFG_DONE (CFG_DONE)
  );

  always #5 MCLK = ~MCLK;

  // Combinational ROM whose data depends on both bank and offset.
  function automatic logic [7:0] rom_model(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  assign ROM_D = rom_model(ROM_ADDR);

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cs, input logic rw,
                              input logic [11:0] addr, input logic [7:0] din,
                              input logic rcs, input logic [14:0] raddr,
                              input logic use_rom, input logic [7:0] d,
                              input logic [2:0] bank);
    vec_t v;
    v.cs = cs; v.rw = rw; v.addr = addr; v.din = din;
    v.rom_cs = rcs; v.raddr = raddr; v.use_rom = use_rom; v.d = d;
    v.bank = bank;
    return v;
  endfunction

  // Drive one access at posedge+1, compare outputs mid-cycle, BANK after.
  task automatic apply(input vec_t v);
    vec_t e;
    logic [7:0] exp_d;
    CS = v.cs; R_W = v.rw; ADDR = v.addr; D_IN = v.din;
    exp_q.push_back(v);
    @(negedge MCLK);
    e = exp_q.pop_front();
    exp_d = e.use_rom ? rom_model(e.raddr) : e.d;
    check($sformatf("rom_cs@%h", e.addr), {15'd0, ROM_CS}, {15'd0, e.rom_cs});
    check($sformatf("rom_addr@%h", e.addr), {1'b0, ROM_ADDR}, {1'b0, e.raddr});
    check($sformatf("d_out@%h", e.addr), {8'd0, D_OUT}, {8'd0, exp_d});
    @(posedge MCLK);
    #1;
    check($sformatf("bank_after@%h", e.addr), {13'd0, BANK}, {13'd0, e.bank});
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  // Assert RES mid-cycle, check the forced state, then configure.
  task automatic do_reset(input logic [1:0] mode, input logic sc,
                          input logic [2:0] exp_bank);
    #2 RES = 1'b1;
    #1;
    check("rst_bank", {13'd0, BANK}, 16'd0);
    check("rst_cfg_done", {15'd0, CFG_DONE}, 16'd0);
    check("rst_rom_cs", {15'd0, ROM_CS}, 16'd0);
    check("rst_d_out", {8'd0, D_OUT}, 16'h0000);
    @(posedge MCLK);
    #1;
    MODE = mode; SC_EN = sc; RES = 1'b0;
    // Unconfigured cycle: hotspot write must be inert.
    CS = 1'b1; ADDR = 12'hFF8; R_W = 1'b0; D_IN = 8'h11;
    #1;
    check("precfg_rom_cs", {15'd0, ROM_CS}, 16'd0);
    check("precfg_d_out", {8'd0, D_OUT}, 16'h0000);
    check("precfg_cfg_done", {15'd0, CFG_DONE}, 16'd0);
    @(posedge MCLK);
    #1;
    check("cfg_done", {15'd0, CFG_DONE}, 16'd1);
    check("cfg_bank", {13'd0, BANK}, {13'd0, exp_bank});
    // Configuration inputs must now be ignored.
    MODE = ~mode; SC_EN = ~sc;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- F8 with Superchip ----
    do_reset(2'b01, 1'b1, 3'd1);
    tbl.push_back(mk(1, 1, 12'hFFC, 8'h00, 1, 15'h1FFC, 1, 8'h00, 3'd1));
    tbl.push_back(mk(1, 1, 12'hFF8, 8'h00, 1, 15'h1FF8, 1, 8'h00, 3'd0));
    tbl.push_back(mk(1, 1, 12'hFFC, 8'h00, 1, 15'h0FFC, 1, 8'h00, 3'd0));
    tbl.push_back(mk(1, 0, 12'hFF9, 8'h5A, 1, 15'h0FF9, 1, 8'h00, 3'd1));
    tbl.push_back(mk(1, 1, 12'hFFA, 8'h00, 1, 15'h1FFA, 1, 8'h00, 3'd1));
    tbl.push_back(mk(1, 1, 12'hFF4, 8'h00, 1, 15'h1FF4, 1, 8'h00, 3'd1));
    tbl.push_back(mk(1, 0, 12'h012, 8'hA5, 0, 15'h1012, 0, 8'hFF, 3'd1));
    tbl.push_back(mk(1, 1, 12'h092, 8'h00, 0, 15'h1092, 0, 8'hA5, 3'd1));
    tbl.push_back(mk(1, 1, 12'h012, 8'h00, 0, 15'h1012, 0, 8'hFF, 3'd1));
    tbl.push_back(mk(1, 0, 12'h092, 8'h33, 0, 15'h1092, 0, 8'hFF, 3'd1));
    tbl.push_back(mk(1, 1, 12'h092, 8'h00, 0, 15'h1092, 0, 8'hA5, 3'd1));
    tbl.push_back(mk(0, 1, 12'hFF8, 8'h00, 0, 15'h1FF8, 0, 8'h00, 3'd1));
    tbl.push_back(mk(1, 1, 12'h100, 8'h00, 1, 15'h1100, 1, 8'h00, 3'd1));
    tbl.push_back(mk(1, 1, 12'h07F, 8'h00, 0, 15'h107F, 0, 8'hFF, 3'd1));
    tbl.push_back(mk(1, 0, 12'h0FF, 8'h44, 0, 15'h10FF, 0, 8'hFF, 3'd1));
    run_table();

    // ---- F4 with Superchip ----
    do_reset(2'b11, 1'b1, 3'd7);
    tbl.push_back(mk(1, 1, 12'hFF9, 8'h00, 1, 15'h7FF9, 1, 8'h00, 3'd5));
    tbl.push_back(mk(1, 1, 12'hFF4, 8'h00, 1, 15'h5FF4, 1, 8'h00, 3'd0));
    tbl.push_back(mk(1, 0, 12'hFFB, 8'h55, 1, 15'h0FFB, 1, 8'h00, 3'd7));
    tbl.push_back(mk(1, 1, 12'hFF9, 8'h00, 1, 15'h7FF9, 1, 8'h00, 3'd5));
    tbl.push_back(mk(1, 1, 12'h092, 8'h00, 0, 15'h5092, 0, 8'hA5, 3'd5));
    run_table();

    // ---- Reset mid-stream while a RAM write is in flight (BANK=5) ----
    CS = 1'b1; R_W = 1'b0; ADDR = 12'h012; D_IN = 8'h00;
    do_reset(2'b10, 1'b1, 3'd3);

    // ---- F6 with Superchip; RAM must still hold $A5 ----
    tbl.push_back(mk(1, 1, 12'h092, 8'h00, 0, 15'h3092, 0, 8'hA5, 3'd3));
    tbl.push_back(mk(1, 1, 12'hFF6, 8'h00, 1, 15'h3FF6, 1, 8'h00, 3'd0));
    tbl.push_back(mk(1, 1, 12'hFF9, 8'h00, 1, 15'h0FF9, 1, 8'h00, 3'd3));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 12'hFF9, 8'h00, 1, 15'h3FF9, 1, 8'h00, 3'd3));
    tbl.push_back(mk(1, 1, 12'hFFA, 8'h00, 1, 15'h3FFA, 1, 8'h00, 3'd3));
    tbl.push_back(mk(1, 1, 12'hFF5, 8'h00, 1, 15'h3FF5, 1, 8'h00, 3'd3));
    run_table();

    // ---- 4K, no Superchip: no hotspots, RAM windows are plain ROM ----
    do_reset(2'b00, 1'b0, 3'd0);
    tbl.push_back(mk(1, 1, 12'hFF8, 8'h00, 1, 15'h0FF8, 1, 8'h00, 3'd0));
    tbl.push_back(mk(1, 1, 12'h012, 8'h00, 1, 15'h0012, 1, 8'h00, 3'd0));
    tbl.push_back(mk(1, 0, 12'h012, 8'h77, 1, 15'h0012, 1, 8'h00, 3'd0));
    tbl.push_back(mk(1, 1, 12'h092, 8'h00, 1, 15'h0092, 1, 8'h00, 3'd0));
    run_table();

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
